// File: rtl/btn_pkg.sv
// Shared definitions for the button event unit.
//   - Register byte offsets inside the 3-word window.
//   - Button bit indices used for STATUS/EVENT bits and counter slots.
//   - reg_sel_e plus decode_sel(): map a word offset to the selected register.
package btn_pkg;

    localparam int unsigned OFF_STATUS = 0;
    localparam int unsigned OFF_EVENT  = 4;
    localparam int unsigned OFF_COUNT  = 8;

    localparam int unsigned BTN_JUMP  = 0;
    localparam int unsigned BTN_PAUSE = 1;
    localparam int unsigned BTN_START = 2;
    localparam int unsigned NUM_BTN   = 3;

    typedef enum logic [1:0] {
        RegStatus = 2'd0,
        RegEvent  = 2'd1,
        RegCount  = 2'd2,
        RegNone   = 2'd3
    } reg_sel_e;

    // word_off is (addr - BASE_ADDR) >> 2, so the byte lane bits never matter.
    function automatic reg_sel_e decode_sel(input logic [29:0] word_off);
        if (word_off == 30'(OFF_STATUS >> 2)) return RegStatus;
        if (word_off == 30'(OFF_EVENT >> 2))  return RegEvent;
        if (word_off == 30'(OFF_COUNT >> 2))  return RegCount;
        return RegNone;
    endfunction

endpackage

// File: rtl/button_event_unit_if.sv
// CPU data-bus slice seen by the button event unit.
//   addr      : CPU byte address (YOut)
//   wdata     : CPU write data (rtOut)
//   we        : CPU write enable (dMemWena), level
//   ena       : address falls inside the register window
//   buttonOut : read data for the selected register
// master = CPU side, slave = peripheral side.
interface button_event_unit_if;

    logic [31:0] addr;
    logic [31:0] wdata;
    logic        we;
    logic        ena;
    logic [31:0] buttonOut;

    modport master (
        output addr,
        output wdata,
        output we,
        input  ena,
        input  buttonOut
    );

    modport slave (
        input  addr,
        input  wdata,
        input  we,
        output ena,
        output buttonOut
    );

endinterface

// File: rtl/btn_debounce.sv
// Single-button conditioner: 2-FF synchroniser, debounce counter, rise pulse.
//   clk    : system clock
//   reset  : asynchronous active-low reset
//   raw    : asynchronous button input
//   stable : debounced level
//   rise   : one-cycle pulse, high in the cycle whose closing edge takes stable 0->1
// A level change is accepted once sync has differed from stable for DEBOUNCE_CYCLES
// consecutive cycles; any return to the stable level restarts the count.
module btn_debounce #(
    parameter int unsigned DEBOUNCE_CYCLES = 1_000_000
) (
    input  logic clk,
    input  logic reset,
    input  logic raw,
    output logic stable,
    output logic rise
);

    localparam int unsigned DcW = $clog2(DEBOUNCE_CYCLES);

    logic           sync1_q;
    logic           sync_q;
    logic           stable_q, stable_d;
    logic [DcW-1:0] dc_q, dc_d;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync1_q  <= 1'b0;
            sync_q   <= 1'b0;
            stable_q <= 1'b0;
            dc_q     <= '0;
        end else begin
            sync1_q  <= raw;
            sync_q   <= sync1_q;
            stable_q <= stable_d;
            dc_q     <= dc_d;
        end
    end

    always_comb begin
        dc_d     = dc_q;
        stable_d = stable_q;
        rise     = 1'b0;
        if (sync_q == stable_q) begin
            dc_d = '0;
        end else if (dc_q == DcW'(DEBOUNCE_CYCLES - 1)) begin
            stable_d = sync_q;
            dc_d     = '0;
            rise     = sync_q;
        end else begin
            dc_d = dc_q + DcW'(1);
        end
    end

    assign stable = stable_q;

endmodule

// File: rtl/button_event_unit.sv
// Memory-mapped button peripheral: debounced levels, sticky W1C press events and
// per-button press counters for jump, pause and start.
//   clk, reset          : system clock, asynchronous active-low reset
//   jump, pause, start  : raw asynchronous buttons
//   bus (slave)         : addr/wdata/we in, ena/buttonOut out (combinational)
// Register window at BASE_ADDR (addr[1:0] ignored):
//   +0x0 STATUS RO  {29'b0, start, pause, jump}
//   +0x4 EVENT  W1C {29'b0, ev_start, ev_pause, ev_jump}
//   +0x8 COUNT  any write clears {8'b0, start_cnt, pause_cnt, jump_cnt}
// Optional build macro BTN_AUTOREPEAT_EN: while jump is held, re-fires a jump event
// every REPEAT_CYCLES cycles after the initial rise.
module button_event_unit
    import btn_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR       = 32'h1001_0040,
    parameter int unsigned DEBOUNCE_CYCLES = 1_000_000,
    parameter int unsigned CNT_W           = 8
`ifdef BTN_AUTOREPEAT_EN
    ,
    parameter int unsigned REPEAT_CYCLES   = 25_000_000
`endif
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                jump,
    input  logic                pause,
    input  logic                start,
    button_event_unit_if.slave  bus
);

    logic [NUM_BTN-1:0] raw;
    logic [NUM_BTN-1:0] stable;
    logic [NUM_BTN-1:0] rise;
    logic [NUM_BTN-1:0] inc;

    assign raw[BTN_JUMP]  = jump;
    assign raw[BTN_PAUSE] = pause;
    assign raw[BTN_START] = start;

    for (genvar g = 0; g < NUM_BTN; g++) begin : g_btn
        btn_debounce #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
        ) u_debounce (
            .clk    (clk),
            .reset  (reset),
            .raw    (raw[g]),
            .stable (stable[g]),
            .rise   (rise[g])
        );
    end

    // ---------------------------------------------------------------- bus decode
    logic [31:0] off;
    reg_sel_e    sel;
    logic        wr_event;
    logic        wr_count;
    logic        bus_unused;

    assign off        = bus.addr - BASE_ADDR;
    assign sel        = decode_sel(off[31:2]);
    assign wr_event   = bus.we && (sel == RegEvent);
    assign wr_count   = bus.we && (sel == RegCount);
    assign bus_unused = ^{bus.wdata[31:NUM_BTN], off[1:0]};

    // ---------------------------------------------------------------- auto-repeat
`ifdef BTN_AUTOREPEAT_EN
    localparam int unsigned RcW = $clog2(REPEAT_CYCLES);

    logic [RcW-1:0] rc_q, rc_d;
    logic           rep;

    // rc_q is 0 on the cycle stable jump first reads 1, so the first repeat lands
    // exactly REPEAT_CYCLES cycles after the initial rise.
    always_comb begin
        rc_d = rc_q;
        rep  = 1'b0;
        if (!stable[BTN_JUMP]) begin
            rc_d = '0;
        end else if (rc_q == RcW'(REPEAT_CYCLES - 1)) begin
            rc_d = '0;
            rep  = 1'b1;
        end else begin
            rc_d = rc_q + RcW'(1);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rc_q <= '0;
        end else begin
            rc_q <= rc_d;
        end
    end

    always_comb begin
        inc           = rise;
        inc[BTN_JUMP] = rise[BTN_JUMP] | rep;
    end
`else
    assign inc = rise;
`endif

    // ---------------------------------------------------------------- events
    logic [NUM_BTN-1:0] ev_q, ev_d;
    logic [NUM_BTN-1:0] clr_mask;

    // Set is ORed in after the clear so a press in the clear cycle is kept.
    always_comb begin
        clr_mask = wr_event ? bus.wdata[NUM_BTN-1:0] : '0;
        ev_d     = (ev_q & ~clr_mask) | inc;
    end

    // ---------------------------------------------------------------- counters
    logic [CNT_W-1:0] cnt_q [NUM_BTN];
    logic [CNT_W-1:0] cnt_d [NUM_BTN];

    always_comb begin
        for (int i = 0; i < NUM_BTN; i++) begin
            cnt_d[i] = cnt_q[i];
            if (wr_count) begin
                cnt_d[i] = inc[i] ? CNT_W'(1) : '0;
            end else if (inc[i]) begin
                cnt_d[i] = cnt_q[i] + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ev_q <= '0;
            for (int i = 0; i < NUM_BTN; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            ev_q <= ev_d;
            for (int i = 0; i < NUM_BTN; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    // ---------------------------------------------------------------- read mux
    logic [31:0] rdata;

    always_comb begin
        rdata = '0;
        unique case (sel)
            RegStatus: rdata = 32'(stable);
            RegEvent:  rdata = 32'(ev_q);
            RegCount:  rdata = 32'({cnt_q[BTN_START], cnt_q[BTN_PAUSE], cnt_q[BTN_JUMP]});
            default:   rdata = '0;
        endcase
    end

    assign bus.ena       = (sel != RegNone);
    assign bus.buttonOut = rdata;

endmodule
